// File: rtl/shared_fifo_pkg.sv
// shared_fifo_pkg: FSM state type and width helpers shared by the dequeue arbiter and its output buffer
package shared_fifo_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int QUEUE_DEF      = 4;
    localparam int DATAWIDTH_DEF  = 128;
    localparam int OBUF_DEPTH_DEF = 4;
    localparam int QWIDTH_DEF     = width_of(QUEUE_DEF);
    localparam int ADDR_DEF       = width_of(OBUF_DEPTH_DEF);

endpackage

// File: rtl/shared_fifo_deq_obuf.sv
// shared_fifo_deq_obuf: first-word-fall-through buffer holding dequeued words with their source queue
module shared_fifo_deq_obuf
    import shared_fifo_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int QWIDTH    = QWIDTH_DEF,
    parameter int DEPTH     = OBUF_DEPTH_DEF,
    localparam int ADDR     = width_of(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_i,
    input  logic [DATAWIDTH-1:0] wr_data_i,
    input  logic [QWIDTH-1:0]    wr_q_i,
    input  logic                 rd_i,
    output logic                 valid_o,
    output logic [DATAWIDTH-1:0] data_o,
    output logic [QWIDTH-1:0]    q_o,
    output logic [ADDR:0]        occ_o
);

    logic [DATAWIDTH-1:0] data_mem [DEPTH];
    logic [QWIDTH-1:0]    q_mem [DEPTH];
    logic [ADDR-1:0]      wr_ptr_q, rd_ptr_q;
    logic [ADDR:0]        occ_q;

    // Head is gated so the outputs read zero whenever the buffer is empty
    assign valid_o = occ_q != '0;
    assign data_o  = valid_o ? data_mem[rd_ptr_q] : '0;
    assign q_o     = valid_o ? q_mem[rd_ptr_q] : '0;
    assign occ_o   = occ_q;

    always_ff @(posedge clock) begin
        if (wr_i) begin
            data_mem[wr_ptr_q] <= wr_data_i;
            q_mem[wr_ptr_q]    <= wr_q_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (wr_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_i) rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_q + (ADDR+1)'(wr_i) - (ADDR+1)'(rd_i);
        end
    end

endmodule

// File: rtl/shared_fifo_deq_arb.sv
// shared_fifo_deq_arb: round-robin dequeue arbiter with credit-managed output buffer; SHARED_FIFO_DEQ_STATS_EN adds per-queue transfer counters
module shared_fifo_deq_arb
    import shared_fifo_pkg::*;
#(
    parameter int QUEUE      = QUEUE_DEF,
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int QWIDTH     = QWIDTH_DEF,
    parameter int RD_LAT     = 1,
    parameter int OBUF_DEPTH = OBUF_DEPTH_DEF
) (
`ifdef SHARED_FIFO_DEQ_STATS_EN
    input  logic [QWIDTH-1:0]    statSel,
    output logic [31:0]          statCnt,
`endif
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 initDone,
    input  logic [QUEUE-1:0]     qEmpty,
    output logic                 pop,
    output logic [QWIDTH-1:0]    popQ,
    input  logic [DATAWIDTH-1:0] popData,
    input  logic [QUEUE-1:0]     qMask,
    input  logic                 halt,
    output logic                 halted,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [DATAWIDTH-1:0] outData,
    output logic [QWIDTH-1:0]    outQ
);

    localparam int ADDR = width_of(OBUF_DEPTH);

    state_t              state_q, state_d;
    logic [QWIDTH-1:0]   last_q, sel, idx;
    logic [QUEUE-1:0]    eligible;
    logic [ADDR:0]       inflight_q, inflight_d, occ;
    logic [RD_LAT-1:0]   tvld_q;
    logic [QWIDTH-1:0]   tag_q [RD_LAT];
    logic                credit_ok, drained, wr, rd;

    assign eligible   = ~qEmpty & qMask;
    // Credits cover every slot a pending pop will need, so a write never finds the buffer full
    assign credit_ok  = ({1'b0, occ} + {1'b0, inflight_q}) < (ADDR+2)'(OBUF_DEPTH);
    assign drained    = (inflight_q == '0) && (occ == '0);
    assign wr         = tvld_q[RD_LAT-1];
    assign rd         = outValid & outReady;
    assign inflight_d = inflight_q + (ADDR+1)'(pop) - (ADDR+1)'(wr);

    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = QUEUE; i >= 1; i--) begin
            idx = QWIDTH'((int'(last_q) + i) % QUEUE);
            if (eligible[idx]) sel = idx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = initDone ? ST_RUN : ST_INIT;
            ST_RUN:    state_d = halt ? ST_DRAIN : ST_RUN;
            ST_DRAIN:  state_d = !halt ? ST_RUN : (drained ? ST_HALTED : ST_DRAIN);
            ST_HALTED: state_d = halt ? ST_HALTED : ST_RUN;
            default:   state_d = ST_INIT;
        endcase
    end

    always_comb begin
        pop    = (state_q == ST_RUN) && (|eligible) && credit_ok;
        popQ   = pop ? sel : '0;
        halted = state_q == ST_HALTED;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q     <= QWIDTH'(QUEUE - 1);
            inflight_q <= '0;
            tvld_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
        end else begin
            if (pop) last_q <= sel;
            inflight_q <= inflight_d;
            tvld_q[0]  <= pop;
            tag_q[0]   <= popQ;
            for (int i = 1; i < RD_LAT; i++) begin
                tvld_q[i] <= tvld_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
        end
    end

    shared_fifo_deq_obuf #(
        .DATAWIDTH (DATAWIDTH),
        .QWIDTH    (QWIDTH),
        .DEPTH     (OBUF_DEPTH)
    ) u_obuf (
        .clock     (clock),
        .reset     (reset),
        .wr_i      (wr),
        .wr_data_i (popData),
        .wr_q_i    (tag_q[RD_LAT-1]),
        .rd_i      (rd),
        .valid_o   (outValid),
        .data_o    (outData),
        .q_o       (outQ),
        .occ_o     (occ)
    );

`ifdef SHARED_FIFO_DEQ_STATS_EN
    logic [31:0] stat_q [QUEUE];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE; i++) stat_q[i] <= '0;
        end else if (rd) begin
            stat_q[outQ] <= stat_q[outQ] + 32'd1;
        end
    end

    assign statCnt = stat_q[statSel];
`endif

endmodule

// File: tb/tb_shared_fifo_deq_arb.sv
// tb_shared_fifo_deq_arb: directed bench with an upstream FIFO model and an in-order output scoreboard
module tb_shared_fifo_deq_arb;
    import shared_fifo_pkg::*;

    localparam int QUEUE = 4;
    localparam int DW    = 128;
    localparam int QW    = 2;

    logic            clock    = 1'b0;
    logic            reset    = 1'b1;
    logic            initDone = 1'b0;
    logic            halt     = 1'b0;
    logic            outReady = 1'b1;
    logic [QUEUE-1:0] qEmpty;
    logic [QUEUE-1:0] qMask   = '1;
    logic            pop, halted, outValid;
    logic [QW-1:0]   popQ, outQ;
    logic [DW-1:0]   popData = '0;
    logic [DW-1:0]   outData;
`ifdef SHARED_FIFO_DEQ_STATS_EN
    logic [QW-1:0]   statSel = '0;
    logic [31:0]     statCnt;
`endif

    int avail [QUEUE];
    int taken [QUEUE];
    int q_xfer [QUEUE];
    int bad_pops = 0;
    int gseq = 0;
    logic [QW+DW-1:0] sb [$];
    int checks = 0;
    int errors = 0;
    int pops_seen = 0;
    int xfers = 0;
    int p0, x0, n, early, gaps;
    logic          s_pop = 1'b0, s_ov = 1'b0;
    logic [QW-1:0] s_popq = '0, s_outq = '0, held_q;
    logic [DW-1:0] s_outd = '0, held_d;

    shared_fifo_deq_arb dut (
`ifdef SHARED_FIFO_DEQ_STATS_EN
        .statSel  (statSel),
        .statCnt  (statCnt),
`endif
        .clock    (clock),
        .reset    (reset),
        .initDone (initDone),
        .qEmpty   (qEmpty),
        .pop      (pop),
        .popQ     (popQ),
        .popData  (popData),
        .qMask    (qMask),
        .halt     (halt),
        .halted   (halted),
        .outValid (outValid),
        .outReady (outReady),
        .outData  (outData),
        .outQ     (outQ)
    );

    always #5 clock = ~clock;

    always_comb begin
        qEmpty = '0;
        for (int i = 0; i < QUEUE; i++) qEmpty[i] = taken[i] >= avail[i];
    end

    // Upstream controller: empty flag follows a pop one cycle later, data returns one cycle after pop
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE; i++) taken[i] <= 0;
        end else if (pop) begin
            if (qEmpty[popQ]) bad_pops <= bad_pops + 1;
            taken[popQ] <= taken[popQ] + 1;
            popData <= {32'(popQ), 32'(taken[popQ]), 32'hDA7A_5EED, 32'(gseq)};
            gseq <= gseq + 1;
            sb.push_back({popQ, 32'(popQ), 32'(taken[popQ]), 32'hDA7A_5EED, 32'(gseq)});
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [QW+DW-1:0] exp_w;
        @(negedge clock);
        s_pop  = pop;
        s_popq = popQ;
        s_ov   = outValid;
        s_outq = outQ;
        s_outd = outData;
        if (pop) pops_seen++;
        if (outValid && outReady) begin
            if (sb.size() != 0) exp_w = sb.pop_front();
            else exp_w = 'x;
            xfers++;
            q_xfer[outQ]++;
            checks++;
            assert ({outQ, outData} === exp_w) else begin
                errors++;
                $error("FAIL xfer observed=%h expected=%h", {outQ, outData}, exp_w);
            end
        end
        @(posedge clock);
        #1;
    endtask

    function automatic bit idle();
        bit r;
        r = (sb.size() == 0) && !outValid;
        for (int i = 0; i < QUEUE; i++) if (taken[i] < avail[i]) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (k < 400 && !idle()) begin
            tick();
            k++;
        end
        check(tag, 128'(k < 400), 128'(1));
    endtask

    initial begin
        for (int i = 0; i < QUEUE; i++) begin
            avail[i]  = 2;
            q_xfer[i] = 0;
        end
        tick();
        tick();
        check("rst_pop", 128'(pop), 128'(0));
        check("rst_popq", 128'(popQ), 128'(0));
        check("rst_valid", 128'(outValid), 128'(0));
        check("rst_data", outData, 128'(0));
        check("rst_outq", 128'(outQ), 128'(0));
        check("rst_halted", 128'(halted), 128'(0));
        check("rst_state", 128'(dut.state_q), 128'(ST_INIT));
        check("rst_lastq", 128'(dut.last_q), 128'(QUEUE - 1));

        reset = 1'b0;
        early = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 10) initDone = 1'b1;
            tick();
            if (s_pop) early++;
        end
        check("no_early_pop", 128'(early), 128'(0));
        check("run_at_11", 128'(dut.state_q), 128'(ST_RUN));

        gaps = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_pop", 128'({s_pop, s_popq}), 128'({1'b1, QW'(k % QUEUE)}));
            if (k >= 2 && !s_ov) gaps++;
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (!s_ov) gaps++;
        end
        check("valid_continuous", 128'(gaps), 128'(0));
        drain("drain_rr");
        check("xfer_rr", 128'(xfers), 128'(8));

        outReady = 1'b0;
        for (int i = 0; i < QUEUE; i++) avail[i] += 10;
        p0 = pops_seen;
        for (int k = 0; k < 4; k++) tick();
        held_d = s_outd;
        held_q = s_outq;
        for (int k = 0; k < 8; k++) tick();
        check("bp_pops", 128'(pops_seen - p0), 128'(4));
        check("bp_pop_idle", 128'(s_pop), 128'(0));
        check("bp_valid", 128'(s_ov), 128'(1));
        check("bp_data_stable", s_outd, held_d);
        check("bp_q_stable", 128'(s_outq), 128'(held_q));
        outReady = 1'b1;
        drain("drain_bp");
        check("xfer_bp", 128'(xfers), 128'(48));

        x0 = q_xfer[2];
        avail[2] += 3;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("q2_pop", 128'({s_pop, s_popq}), 128'({1'b1, 2'd2}));
        end
        tick();
        check("q2_stop", 128'(s_pop), 128'(0));
        drain("drain_q2");
        check("q2_outq", 128'(q_xfer[2] - x0), 128'(3));
        check("xfer_q2", 128'(xfers), 128'(51));

        for (int i = 0; i < QUEUE; i++) avail[i] += 5;
        p0 = pops_seen;
        x0 = xfers;
        tick();
        halt = 1'b1;
        tick();
        check("halt_two_pops", 128'(pops_seen - p0), 128'(2));
        n = 0;
        while (n < 40 && halted !== 1'b1) begin
            tick();
            n++;
        end
        check("halted_reached", 128'(n < 40), 128'(1));
        check("halt_no_extra_pop", 128'(pops_seen - p0), 128'(2));
        check("halt_delivered", 128'(xfers - x0), 128'(2));
        check("halt_buf_empty", 128'(outValid), 128'(0));
        for (int k = 0; k < 10; k++) tick();
        check("halt_hold_pops", 128'(pops_seen - p0), 128'(2));
        check("halt_hold", 128'(halted), 128'(1));
        halt = 1'b0;
        tick();
        check("unhalt_state", 128'(dut.state_q), 128'(ST_RUN));
        check("unhalt_halted", 128'(halted), 128'(0));
        tick();
        check("resume_pop", 128'(s_pop), 128'(1));
        drain("drain_halt");

        outReady = 1'b0;
        avail[0] += 1;
        tick();
        tick();
        tick();
        halt = 1'b1;
        tick();
        tick();
        check("drain_holds", 128'(dut.state_q), 128'(ST_DRAIN));
        halt = 1'b0;
        tick();
        check("drain_to_run", 128'(dut.state_q), 128'(ST_RUN));
        outReady = 1'b1;
        drain("drain_d2r");
        check("no_empty_pops", 128'(bad_pops), 128'(0));

`ifdef SHARED_FIFO_DEQ_STATS_EN
        for (int i = 0; i < QUEUE; i++) begin
            statSel = QW'(i);
            #1;
            check("stat_all", 128'(statCnt), 128'(q_xfer[i]));
        end
        reset = 1'b1;
        for (int i = 0; i < QUEUE; i++) avail[i] = 0;
        tick();
        reset = 1'b0;
        avail[1] = 5;
        drain("drain_stat");
        statSel = QW'(1);
        #1;
        check("stat_q1", 128'(statCnt), 128'(5));
        statSel = QW'(0);
        #1;
        check("stat_q0", 128'(statCnt), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
